i2c_master_arbiter: RTL and testbench

- Round-robin arbiter and transaction sequencer that shares one I2C master among N_REQ requesters.
- Each requester presents a 16-bit word: address byte [15:8], data byte [7:0].
- The block grants one requester, drives the master's active-low start and 16-bit word, and times the transfer.
- It samples the master's ACK/NACK and returns a per-requester done/error pulse.
- It sits between the system logic and the I2C master; it is the only driver of that master's start and word inputs.

---
 rtl/i2c_pkg.sv | 35 +++
 rtl/i2c_master_arbiter_if.sv | 33 +++
 rtl/i2c_master_arbiter_rr_arbiter.sv | 37 +++
 rtl/i2c_master_arbiter.sv | 143 ++++++++++++++
 tb/tb_i2c_master_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master arbiter slice.
// Contents:
//   state_t          sequencer states (IDLE, ARB, LAUNCH, WAIT, REPORT, GUARD)
//   I2C_WORD_W       width of the word handed to the I2C master
//   DEF_*            default timing, derived from the master's clock divider
//   max_int()        constant helper used to size counters
package i2c_pkg;

   localparam int I2C_WORD_W   = 16;

   // The master toggles its I2C clock every I2C_HALF_DIV clk; one bit period
   // is two halves plus two cycles of edge overhead (502 clk).
   localparam int I2C_HALF_DIV = 250;
   localparam int I2C_BIT_CLKS = 2 * I2C_HALF_DIV + 2;

   // Start must survive two bit periods so the master's sampling sees it.
   localparam int DEF_START_HOLD = 2 * I2C_BIT_CLKS + 96;    // 1100
   // A full transfer is 22 bit periods; the rest is margin.
   localparam int DEF_TXN_CYCLES = 22 * I2C_BIT_CLKS + 956;  // 12000
   localparam int DEF_GAP        = 600;

   typedef enum logic [2:0] {
      IDLE,
      ARB,
      LAUNCH,
      WAIT,
      REPORT,
      GUARD
   } state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/i2c_master_arbiter_if.sv
// Bundle between requesters, the arbiter and the I2C master.
// Requester side : req, req_word (word i at [16i+15:16i]), gnt, done, err
// Master side    : m_start_n (active low), m_word, m_ack, m_nack
// Modports:
//   master - the arbiter (drives grants, pulses and the master's inputs)
//   slave  - the environment (requesters plus the I2C master)
interface i2c_master_arbiter_if
   import i2c_pkg::*;
#(
   parameter int N_REQ = 4
);

   logic [N_REQ-1:0]            req;
   logic [I2C_WORD_W*N_REQ-1:0] req_word;
   logic [N_REQ-1:0]            gnt;
   logic [N_REQ-1:0]            done;
   logic [N_REQ-1:0]            err;
   logic                        m_start_n;
   logic [I2C_WORD_W-1:0]       m_word;
   logic                        m_ack;
   logic                        m_nack;

   modport master (
      input  req, req_word, m_ack, m_nack,
      output gnt, done, err, m_start_n, m_word
   );

   modport slave (
      output req, req_word, m_ack, m_nack,
      input  gnt, done, err, m_start_n, m_word
   );

endinterface

// File: rtl/i2c_master_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
// Ports:
//   req   in   N_REQ  request vector
//   ptr   in   PTR_W  highest-priority position for this decision
//   grant out  N_REQ  one-hot winner, all zero when no request
//   idx   out  PTR_W  index of the winner (0 when no request)
// Search order is ptr, ptr+1, ..., N_REQ-1, 0, ..., ptr-1.
module rr_arbiter #(
   parameter  int N_REQ = 4,
   localparam int PTR_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N_REQ-1:0] grant,
   output logic [PTR_W-1:0] idx
);

   always_comb begin
      logic [PTR_W-1:0] pos;
      logic             found;
      // NOTE: every variable gets a value before any branch, so no latch can be
      // inferred; blocking '=' is correct here because this is pure logic.
      grant = '0;
      idx   = '0;
      found = 1'b0;
      pos   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         pos = PTR_W'((int'(ptr) + k) % N_REQ);
         if (!found && req[pos]) begin
            grant[pos] = 1'b1;
            idx        = pos;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Shares one I2C master among N_REQ requesters.
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-high reset
//   bus   if   i2c_master_arbiter_if.master (requester and master signals)
//   busy  out  high in every state except IDLE
// One transfer: ARB picks a winner round-robin, LAUNCH holds m_start_n low
// for START_HOLD cycles, WAIT collects sticky ACK/NACK until TXN_CYCLES have
// elapsed since the grant, REPORT emits done/err, GUARD enforces bus-free
// time. Reset lands in GUARD with a full transfer length so a master
// transfer already in flight can drain.
module i2c_master_arbiter
   import i2c_pkg::*;
#(
   parameter int N_REQ      = 4,
   parameter int START_HOLD = DEF_START_HOLD,
   parameter int TXN_CYCLES = DEF_TXN_CYCLES,
   parameter int GAP        = DEF_GAP
) (
   input  logic                 clk,
   input  logic                 rst,
   i2c_master_arbiter_if.master bus,
   output logic                 busy
);

   localparam int PTR_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(max_int(TXN_CYCLES, GAP) + 1);

   state_t                 state;
   logic [CNT_W-1:0]       cnt;
   logic [PTR_W-1:0]       ptr;
   logic [PTR_W-1:0]       winner;
   logic                   ack_seen;
   logic                   nack_seen;

   logic [N_REQ-1:0]       arb_grant;
   logic [PTR_W-1:0]       arb_idx;
   logic [I2C_WORD_W-1:0]  words [N_REQ];

   rr_arbiter #(.N_REQ(N_REQ)) u_rr (
      .req   (bus.req),
      .ptr   (ptr),
      .grant (arb_grant),
      .idx   (arb_idx)
   );

   always_comb begin
      for (int k = 0; k < N_REQ; k++) begin
         words[k] = bus.req_word[k*I2C_WORD_W +: I2C_WORD_W];
      end
   end

   assign busy = (state != IDLE);

   // NOTE: all state and outputs use '<=' so every register sees the values
   // from before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      // NOTE: reset covers every register; the FSM relies on known flags and
      // pointer values, and there is no storage array to exempt.
      if (rst) begin
         state         <= GUARD;
         cnt           <= CNT_W'(TXN_CYCLES);
         ptr           <= '0;
         winner        <= '0;
         ack_seen      <= 1'b0;
         nack_seen     <= 1'b0;
         bus.gnt       <= '0;
         bus.done      <= '0;
         bus.err       <= '0;
         bus.m_start_n <= 1'b1;
         bus.m_word    <= '0;
      end else begin
         // done/err are single-cycle pulses.
         bus.done <= '0;
         bus.err  <= '0;

         // ACK/NACK are collected from the first LAUNCH cycle onward.
         if (state == LAUNCH || state == WAIT) begin
            ack_seen  <= ack_seen  | bus.m_ack;
            nack_seen <= nack_seen | bus.m_nack;
         end

         case (state)
            IDLE: begin
               if (|bus.req) state <= ARB;
            end

            ARB: begin
               // The request may have dropped since IDLE; then nobody wins.
               if (|bus.req) begin
                  bus.gnt       <= arb_grant;
                  bus.m_word    <= words[arb_idx];
                  bus.m_start_n <= 1'b0;
                  winner        <= arb_idx;
                  ptr           <= (arb_idx == PTR_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
                  ack_seen      <= 1'b0;
                  nack_seen     <= 1'b0;
                  cnt           <= '0;
                  state         <= LAUNCH;
               end else begin
                  state <= IDLE;
               end
            end

            LAUNCH: begin
               // cnt keeps running into WAIT so it measures the whole transfer.
               cnt <= cnt + 1'b1;
               if (cnt == CNT_W'(START_HOLD - 1)) begin
                  bus.m_start_n <= 1'b1;
                  state         <= WAIT;
               end
            end

            WAIT: begin
               cnt <= cnt + 1'b1;
               if (cnt == CNT_W'(TXN_CYCLES - 1)) state <= REPORT;
            end

            REPORT: begin
               // Silence (no ACK at all) counts as a failure as well as NACK.
               bus.done[winner] <= 1'b1;
               bus.err[winner]  <= nack_seen | ~ack_seen;
               bus.gnt          <= '0;
               cnt              <= CNT_W'(GAP);
               state            <= GUARD;
            end

            GUARD: begin
               // Lasts exactly the loaded count; requests wait meanwhile.
               if (cnt <= CNT_W'(1)) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Self-checking bench for i2c_master_arbiter (N_REQ=4, START_HOLD=4,
// TXN_CYCLES=20, GAP=3). A timestamp model predicts every output each
// cycle; directed scenarios add literal expectations.
module tb_i2c_master_arbiter;

   localparam int N   = 4;
   localparam int SH  = 4;
   localparam int TXN = 20;
   localparam int GP  = 3;

   logic clk;
   logic rst;
   logic busy;

   i2c_master_arbiter_if #(.N_REQ(N)) bus ();

   i2c_master_arbiter #(
      .N_REQ      (N),
      .START_HOLD (SH),
      .TXN_CYCLES (TXN),
      .GAP        (GP)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   // Time is counted in cycles (one per posedge). A transfer is described by
   // the cycle t0 in which gnt first shows; everything else follows from t0.
   int          cyc       = 0;
   int          guard_end = 0;   // first cycle that may be IDLE
   int          t0        = -1;  // grant cycle of the running transfer
   int          arb_c     = -1;  // cycle that is the arbitration cycle
   logic [1:0]  mptr      = '0;
   logic [1:0]  win       = '0;
   bit          ack_any   = 0;
   bit          nack_any  = 0;
   bit          model_ok  = 0;
   logic [3:0]  exp_gnt   = '0;
   logic [3:0]  exp_done  = '0;
   logic [3:0]  exp_err   = '0;
   logic        exp_start_n = 1'b1;
   logic        exp_busy    = 1'b1;
   logic [15:0] exp_word    = '0;

   function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
      logic [1:0] j;
      for (int k = 0; k < 4; k++) begin
         j = p + 2'(k);
         if (r[j]) return j;
      end
      return p;
   endfunction

   function automatic logic [15:0] word_of(input logic [63:0] w, input logic [1:0] i);
      case (i)
         2'd0:    return w[15:0];
         2'd1:    return w[31:16];
         2'd2:    return w[47:32];
         default: return w[63:48];
      endcase
   endfunction

   always @(posedge clk) begin
      bit was_idle;
      cyc++;
      exp_done = '0;
      exp_err  = '0;
      if (rst) begin
         guard_end = cyc + TXN;
         t0        = -1;
         arb_c     = -1;
         mptr      = '0;
         exp_word  = '0;
         model_ok  = 1;
      end else if (model_ok) begin
         was_idle = (t0 < 0) && (arb_c < 0) && (cyc - 1 >= guard_end);
         if (t0 >= 0 && cyc - 1 <= t0 + TXN - 1) begin
            ack_any  = ack_any  | bus.m_ack;
            nack_any = nack_any | bus.m_nack;
         end
         if (t0 >= 0 && cyc == t0 + TXN + 1) begin
            exp_done[win] = 1'b1;
            exp_err[win]  = nack_any | !ack_any;
            guard_end     = cyc + GP;
            t0            = -1;
         end
         if (arb_c == cyc - 1) begin
            arb_c = -1;
            if (bus.req != 0) begin
               win      = rr_pick(bus.req, mptr);
               mptr     = win + 2'd1;
               t0       = cyc;
               exp_word = word_of(bus.req_word, win);
               ack_any  = 0;
               nack_any = 0;
            end
         end else if (was_idle && bus.req != 0) begin
            arb_c = cyc;
         end
      end
      exp_gnt     = (t0 >= 0 && cyc <= t0 + TXN) ? (4'b0001 << win) : 4'b0000;
      exp_start_n = !(t0 >= 0 && cyc <= t0 + SH - 1);
      exp_busy    = !((t0 < 0) && (arb_c < 0) && (cyc >= guard_end));
   end

   always @(negedge clk) begin
      if (model_ok) begin
         check("gnt",       32'(bus.gnt),       32'(exp_gnt));
         check("done",      32'(bus.done),      32'(exp_done));
         check("err",       32'(bus.err),       32'(exp_err));
         check("m_start_n", 32'(bus.m_start_n), 32'(exp_start_n));
         check("m_word",    32'(bus.m_word),    32'(exp_word));
         check("busy",      32'(busy),          32'(exp_busy));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_idle();
      int n = 0;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("idle_reached", 32'(busy), 0);
   endtask

   // Waits for a grant, then follows the transfer to its done pulse. m_ack /
   // m_nack are raised for one cycle at offset ack_k / nack_k from the grant.
   task automatic run_xfer(input int ack_k, input int nack_k,
                           output logic [3:0] g_o, output int lat_o,
                           output int low_o, output int done_o,
                           output logic [3:0] d_o, output logic [3:0] e_o);
      lat_o = 0;
      while (bus.gnt == 0 && lat_o < 100) begin
         @(negedge clk);
         lat_o++;
      end
      check("gnt_seen", 32'(bus.gnt != 0), 1);
      g_o    = bus.gnt;
      low_o  = 0;
      done_o = -1;
      d_o    = '0;
      e_o    = '0;
      for (int k = 0; k < 40 && done_o < 0; k++) begin
         if (k > 0) @(negedge clk);
         bus.m_ack  = (k == ack_k);
         bus.m_nack = (k == nack_k);
         if (!bus.m_start_n) low_o++;
         if (bus.done != 0) begin
            done_o = k;
            d_o    = bus.done;
            e_o    = bus.err;
         end
      end
      bus.m_ack  = 1'b0;
      bus.m_nack = 1'b0;
   endtask

   // ---------------- directed scenarios ----------------
   logic [3:0] fair_order [5];

   initial begin
      logic [3:0] g, d, e;
      int lat, low, dat, n;
      bit seen;

      fair_order   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      rst          = 1'b1;
      bus.req      = '0;
      bus.req_word = {16'hE5F6, 16'hC3D4, 16'hB1C2, 16'hA055};
      bus.m_ack    = 1'b0;
      bus.m_nack   = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_gnt",       32'(bus.gnt),       0);
      check("rst_done",      32'(bus.done),      0);
      check("rst_err",       32'(bus.err),       0);
      check("rst_m_start_n", 32'(bus.m_start_n), 1);
      check("rst_m_word",    32'(bus.m_word),    0);
      check("rst_busy",      32'(busy),          1);
      rst = 1'b0;

      // Post-reset guard lasts a full transfer length.
      n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("post_rst_guard", n, 20);

      // Single request with ACK.
      bus.req = 4'b0001;
      run_xfer(8, -1, g, lat, low, dat, d, e);
      bus.req = '0;
      check("single_lat",   lat, 2);
      check("single_gnt",   32'(g), 'b0001);
      check("single_word",  32'(bus.m_word), 'hA055);
      check("single_start", low, 4);
      check("single_done_at", dat, 21);
      check("single_done",  32'(d), 'b0001);
      check("single_err",   32'(e), 0);
      wait_idle();

      // NACK path, then guard length.
      bus.req = 4'b0010;
      run_xfer(-1, 6, g, lat, low, dat, d, e);
      bus.req = '0;
      check("nack_gnt",     32'(g), 'b0010);
      check("nack_done_at", dat, 21);
      check("nack_done",    32'(d), 'b0010);
      check("nack_err",     32'(e), 'b0010);
      n = 0;
      while (busy && n < 50) begin
         n++;
         @(negedge clk);
      end
      check("nack_guard", n, 3);

      // No response at all.
      bus.req = 4'b0100;
      run_xfer(-1, -1, g, lat, low, dat, d, e);
      bus.req = '0;
      check("silent_gnt",     32'(g), 'b0100);
      check("silent_done_at", dat, 21);
      check("silent_err",     32'(e), 'b0100);
      wait_idle();

      // Wrap-around: ptr is 3, so 0 wins over 2, then 2 follows.
      bus.req = 4'b0101;
      run_xfer(5, -1, g, lat, low, dat, d, e);
      check("wrap_first",  32'(g), 'b0001);
      check("wrap_err0",   32'(e), 0);
      run_xfer(5, -1, g, lat, low, dat, d, e);
      bus.req = '0;
      check("wrap_second", 32'(g), 'b0100);
      wait_idle();

      // Reset in the middle of WAIT.
      bus.req = 4'b1000;
      lat = 0;
      while (bus.gnt == 0 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check("rstmid_gnt", 32'(bus.gnt), 'b1000);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst     = 1'b0;
      bus.req = 4'b1111;
      check("rstmid_gnt_clr",   32'(bus.gnt),       0);
      check("rstmid_start_n",   32'(bus.m_start_n), 1);
      check("rstmid_busy",      32'(busy),          1);
      n    = 0;
      seen = 0;
      while (busy && n < 100) begin
         if (bus.done != 0) seen = 1;
         n++;
         @(negedge clk);
      end
      check("rstmid_guard",   n, 20);
      check("rstmid_no_done", 32'(seen), 0);

      // Fairness with all requests held.
      for (int i = 0; i < 5; i++) begin
         run_xfer(3, -1, g, lat, low, dat, d, e);
         check("fair_gnt",  32'(g), 32'(fair_order[i]));
         check("fair_done", 32'(d), 32'(fair_order[i]));
      end
      bus.req = '0;
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not complete, got t=%0t", $time);
      $fatal(1, "bench stopped");
   end

endmodule
